// File: rtl/branch_predictor_btb.sv
// IF-stage BTB + 2-bit BHT branch predictor, trained from EX resolution.
// Define BP_GSHARE_EN to index the BHT with pc XOR global history (gshare).
module branch_predictor_btb #(
  parameter int BTB_IDX_BITS = 5,
  parameter int BHT_IDX_BITS = 7,
  parameter int GHR_BITS     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             if_pc,
  output logic                    prediction,
  output logic                    tag_comp,
  output logic [31:0]             predicted_pc,
  output logic [BHT_IDX_BITS-1:0] if_bht_idx,
  input  logic                    ex_valid,
  input  logic                    ex_stall,
  input  logic [6:0]              ex_opcode,
  input  logic [31:0]             ex_pc,
  input  logic                    ex_br_en,
  input  logic [31:0]             ex_target,
  input  logic                    ex_pred_taken,
  input  logic [31:0]             ex_pred_pc,
  input  logic [BHT_IDX_BITS-1:0] ex_bht_idx,
  output logic [31:0]             branch_count,
  output logic [31:0]             mispredict_count
);

  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int BHT_N = 1 << BHT_IDX_BITS;
  localparam int TAG_W = 30 - BTB_IDX_BITS;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] ST  = 2'b11;

  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [31:0]       btb_target [BTB_N];
  logic              btb_jump   [BTB_N];
  logic [1:0]        bht        [BHT_N];

  logic [BTB_IDX_BITS-1:0] if_btb_idx;
  logic [TAG_W-1:0]        if_tag;
  logic [BHT_IDX_BITS-1:0] pc_bht_idx;

  assign if_btb_idx = if_pc[BTB_IDX_BITS+1:2];
  assign if_tag     = if_pc[31:BTB_IDX_BITS+2];
  assign pc_bht_idx = if_pc[BHT_IDX_BITS+1:2];

  logic is_br;
  logic is_jmp;
  logic fire;
  logic mispredict;

  assign is_br  = ex_opcode == OP_BR;
  assign is_jmp = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
  assign fire   = ex_valid && !ex_stall && (is_br || is_jmp);

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else if (fire && is_br)
      ghr <= {ghr[GHR_BITS-2:0], ex_br_en};
  end

  assign if_bht_idx = pc_bht_idx ^ BHT_IDX_BITS'(ghr);

  logic unused;
  assign unused = ^{if_pc[1:0], ex_pc[1:0]};
`else
  assign if_bht_idx = pc_bht_idx;

  logic unused;
  assign unused = ^{if_pc[1:0], ex_pc[1:0], 32'(GHR_BITS)};
`endif

  assign tag_comp = btb_valid[if_btb_idx]
                 && (btb_tag[if_btb_idx] == if_tag);

  assign prediction = tag_comp
                   && (btb_jump[if_btb_idx] || bht[if_bht_idx][1]);

  assign predicted_pc = prediction ? btb_target[if_btb_idx]
                                   : if_pc + 32'd4;

  assign mispredict = (ex_br_en != ex_pred_taken)
                   || (ex_br_en && (ex_pred_pc != ex_target));

  logic [BTB_IDX_BITS-1:0] ex_btb_idx;
  logic [TAG_W-1:0]        ex_tag;
  logic                    btb_wr;

  assign ex_btb_idx = ex_pc[BTB_IDX_BITS+1:2];
  assign ex_tag     = ex_pc[31:BTB_IDX_BITS+2];
  assign btb_wr     = fire && (is_jmp || ex_br_en);

  logic [1:0] bht_cur;
  logic [1:0] bht_next;

  always_comb begin
    bht_cur  = bht[ex_bht_idx];
    bht_next = bht_cur;
    unique case (1'b1)
      ex_br_en && (bht_cur != ST):   bht_next = 2'(bht_cur + 2'd1);
      !ex_br_en && (bht_cur != SNT): bht_next = 2'(bht_cur - 2'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++)
        btb_valid[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_valid[ex_btb_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[ex_btb_idx]    <= ex_tag;
      btb_target[ex_btb_idx] <= ex_target;
      btb_jump[ex_btb_idx]   <= is_jmp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++)
        bht[i] <= WNT;
    end else if (fire && is_br) begin
      bht[ex_bht_idx] <= bht_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (fire) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb against an array-based
// reference model; directed scenarios followed by random traffic.
module tb_branch_predictor_btb;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        prediction;
  logic        tag_comp;
  logic [31:0] predicted_pc;
  logic [6:0]  if_bht_idx;
  logic        ex_valid;
  logic        ex_stall;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic [6:0]  ex_bht_idx;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor_btb dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .prediction(prediction), .tag_comp(tag_comp),
    .predicted_pc(predicted_pc), .if_bht_idx(if_bht_idx),
    .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_br_en(ex_br_en), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
    .ex_bht_idx(ex_bht_idx), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        tc;
    logic        pr;
    logic [31:0] ppc;
    logic [6:0]  bi;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  logic look_v;
  int   tests;
  int   fails;

  // reference model: 32-entry BTB, 128-entry BHT of ints 0..3
  bit        mv   [32];
  bit [31:0] mtag [32];
  bit [31:0] mtgt [32];
  bit        mjmp [32];
  int        mbht [128];
  int        mghr;
  bit [31:0] mbc;
  bit [31:0] mmc;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mv[i] = 0;
    for (int i = 0; i < 128; i++) mbht[i] = 1;
    mghr = 0;
    mbc  = 0;
    mmc  = 0;
  endfunction

  function automatic int bidx_of(bit [31:0] pc);
`ifdef BP_GSHARE_EN
    return int'(((pc >> 2) ^ mghr) % 128);
`else
    return int'((pc >> 2) % 128);
`endif
  endfunction

  function automatic exp_t predict(bit [31:0] pc);
    exp_t e;
    int   i;
    i      = int'((pc >> 2) % 32);
    e.pc   = pc;
    e.bi   = 7'(bidx_of(pc));
    e.tc   = mv[i] && (mtag[i] == (pc >> 7));
    e.pr   = e.tc && (mjmp[i] || mbht[e.bi] >= 2);
    e.ppc  = e.pr ? mtgt[i] : pc + 32'd4;
    e.bc   = mbc;
    e.mc   = mmc;
    return e;
  endfunction

  function automatic void model_train(bit [6:0] op, bit [31:0] pc,
      bit br, bit [31:0] tgt, bit pt, bit [31:0] ppc, int bi);
    int  i;
    bit  jmp;
    i   = int'((pc >> 2) % 32);
    jmp = (op == OP_JAL) || (op == OP_JALR);
    if (!jmp && op != OP_BR) return;
    mbc = mbc + 1;
    if ((br != pt) || (br && ppc != tgt)) mmc = mmc + 1;
    if (op == OP_BR) begin
      if (br) mbht[bi] = (mbht[bi] == 3) ? 3 : mbht[bi] + 1;
      else    mbht[bi] = (mbht[bi] == 0) ? 0 : mbht[bi] - 1;
      mghr = ((mghr << 1) | int'(br)) % 128;
    end
    if (jmp || br) begin
      mv[i]   = 1;
      mtag[i] = pc >> 7;
      mtgt[i] = tgt;
      mjmp[i] = jmp;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (look_v) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tag_comp", 32'(tag_comp), 32'(e.tc));
        chk("prediction", 32'(prediction), 32'(e.pr));
        chk("predicted_pc", predicted_pc, e.ppc);
        chk("if_bht_idx", 32'(if_bht_idx), 32'(e.bi));
        chk("branch_count", branch_count, e.bc);
        chk("mispredict_count", mispredict_count, e.mc);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] pc,
      input logic v, input logic st, input logic [6:0] op,
      input logic [31:0] epc, input logic br, input logic [31:0] tgt,
      input logic pt, input logic [31:0] ppc, input logic [6:0] bi);
    @(posedge clk);
    #1;
    rst_n         = r;
    if_pc         = pc;
    ex_valid      = v;
    ex_stall      = st;
    ex_opcode     = op;
    ex_pc         = epc;
    ex_br_en      = br;
    ex_target     = tgt;
    ex_pred_taken = pt;
    ex_pred_pc    = ppc;
    ex_bht_idx    = bi;
    if (!r) model_reset();
    q.push_back(predict(pc));
    look_v = 1'b1;
    if (r && v && !st) model_train(op, epc, br, tgt, pt, ppc, int'(bi));
  endtask

  task automatic idle(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, OP_ALU, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h0, 7'h0);
  endtask

  // EX instruction carrying what the front end would have predicted
  task automatic train(input logic [31:0] lpc, input logic [6:0] op,
      input logic [31:0] epc, input logic br, input logic [31:0] tgt);
    exp_t p;
    p = predict(epc);
    step(1'b1, lpc, 1'b1, 1'b0, op, epc, br, tgt, p.pr, p.ppc, p.bi);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom % 6)
      0: return 32'h100;
      1: return 32'h104;
      2: return 32'h180;
      3: return 32'h200;
      4: return 32'h280;
      default: return $urandom & 32'hffff_fffc;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t p;
    tests  = 0;
    fails  = 0;
    look_v = 1'b0;
    rst_n  = 1'b0;
    if_pc  = 32'h100;
    ex_valid = 0; ex_stall = 0; ex_opcode = OP_ALU; ex_pc = 0;
    ex_br_en = 0; ex_target = 0; ex_pred_taken = 0;
    ex_pred_pc = 0; ex_bht_idx = 0;
    model_reset();

    step(1'b0, 32'h100, 1'b0, 1'b0, OP_ALU, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h0, 7'h0);
    idle(32'h100);

    train(32'h100, OP_BR, 32'h100, 1'b1, 32'h80);
    train(32'h100, OP_BR, 32'h100, 1'b1, 32'h80);
    idle(32'h100);

    repeat (3) train(32'h100, OP_BR, 32'h100, 1'b0, 32'h80);
    idle(32'h100);

    train(32'h200, OP_JAL, 32'h200, 1'b1, 32'h400);
    idle(32'h200);

    p = predict(32'h104);
    repeat (4)
      step(1'b1, 32'h104, 1'b1, 1'b1, OP_BR, 32'h104, 1'b1, 32'h40,
           p.pr, p.ppc, p.bi);
    step(1'b1, 32'h104, 1'b1, 1'b0, OP_BR, 32'h104, 1'b1, 32'h40,
         p.pr, p.ppc, p.bi);
    idle(32'h104);
    idle(32'h180);

    train(32'h100, OP_JALR, 32'h180, 1'b1, 32'h900);
    idle(32'h100);
    idle(32'h180);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] lpc, epc, tgt, ppc;
      logic [6:0]  op, bi;
      logic        v, st, br, pt;
      int          k;
      lpc = pick_pc();
      epc = pick_pc();
      k   = int'($urandom % 8);
      op  = (k < 4) ? OP_BR : (k == 4) ? OP_JAL :
            (k == 5) ? OP_JALR : OP_ALU;
      v   = ($urandom % 10) != 0;
      st  = ($urandom % 7) == 0;
      br  = (op == OP_BR) ? 1'($urandom) : 1'b1;
      tgt = ($urandom % 2) ? 32'h80 : ($urandom & 32'hffff_fffc);
      p   = predict(epc);
      if ($urandom % 2) begin
        pt  = p.pr;
        ppc = p.ppc;
      end else begin
        pt  = 1'($urandom);
        ppc = ($urandom % 2) ? tgt : epc + 32'd4;
      end
      bi = (($urandom % 8) == 0) ? 7'($urandom) : p.bi;
      step(1'b1, lpc, v, st, op, epc, br, tgt, pt, ppc, bi);
    end

    step(1'b0, 32'h100, 1'b1, 1'b0, OP_BR, 32'h100, 1'b1, 32'h80,
         1'b0, 32'h104, 7'h40);
    step(1'b0, 32'h200, 1'b1, 1'b0, OP_JAL, 32'h200, 1'b1, 32'h400,
         1'b0, 32'h204, 7'h0);
    idle(32'h100);
    idle(32'h200);

    train(32'h100, OP_BR, 32'h100, 1'b1, 32'h80);
    train(32'h100, OP_BR, 32'h100, 1'b1, 32'h80);
    train(32'h100, OP_BR, 32'h100, 1'b0, 32'h80);
    idle(32'h100);
    idle(32'h104);

    @(negedge clk);
    #1;
    look_v = 1'b0;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
